plt_collision_sched: RTL and testbench
======================================

Name: plt_collision_sched

Overview:
Per-frame vertical-resolution scheduler that time-shares one main-platform collision checker among NUM_PLAYERS characters. On each frame tick it snapshots every character's position and vertical velocity. It then walks the characters in index order, computes each proposed next_y and resolves it against the platform (snap-to-top on landing). Each result is written back through a one-cycle update strobe to the character state registers. It sits between the per-character motion logic and the position registers feeding the renderer.

Parameters:
NUM_PLAYERS, 2, number of characters scheduled per frame (1..8)
WIDTH, 16, character half-width in pixels; the checker uses WIDTH*2
HEIGHT, 16, character half-height in pixels; the checker uses HEIGHT*2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse, start of frame update
x_pos  in  NUM_PLAYERS*11  packed signed x per character; index k at bits [11k+10:11k]
y_pos  in  NUM_PLAYERS*11  packed signed y (sprite top) per character
y_vel  in  NUM_PLAYERS*8  packed signed vertical velocity per character, pixels/frame, +down
upd_valid  out  1  one-cycle strobe: write-back for upd_idx is valid
upd_idx  out  3  character index being written back
upd_y  out  11  resolved signed y for upd_idx
upd_grounded  out  1  character rests on the platform after this frame
busy  out  1  scheduler mid-frame
done  out  1  one-cycle pulse, coincident with the final upd_valid of a frame
overrun  out  1  sticky flag: frame_tick arrived while busy

Behaviour:
- Reset (async, rst=1): state IDLE, idx=0. All outputs 0, including overrun. Snapshot registers are cleared.
- FSM states are IDLE, CALC, RESOLVE.
  - IDLE: on frame_tick, register all x_pos/y_pos/y_vel into snapshot registers, set idx=0, go to CALC. Live inputs are not sampled again during the frame.
  - CALC(idx): register next_y = sat11(y_snap[idx] + sext(y_vel_snap[idx])). Register the checker inputs (x, y, next_y). Go to RESOLVE.
  - RESOLVE(idx): the checker is combinational on the registered inputs.
    - If touching: upd_y = PLATFORM_Y - 2*HEIGHT and upd_grounded = 1.
    - Otherwise: upd_y = next_y and upd_grounded = 0.
    - These values and upd_idx = idx are registered, and upd_valid is registered to 1 for the next cycle.
    - If idx == NUM_PLAYERS-1: register done=1 and go to IDLE. Otherwise idx+1 and go to CALC.
- Latency: with frame_tick sampled at edge E0, the update for character k is visible for exactly one cycle after edge E0+2(k+1).
  - done coincides with the update for k = NUM_PLAYERS-1.
  - A frame completes in 2*NUM_PLAYERS cycles.
- busy = (state != IDLE). busy is low in the cycle carrying the last upd_valid/done. A frame_tick in that cycle is accepted normally.
- Arithmetic:
  - The sum is computed at 12 bits signed.
  - sat11 clamps to [-1024, 1023].
  - The checker compares at ≥12-bit signed width so that y + 2*HEIGHT cannot wrap.
- Contact semantics:
  - A character resting with its bottom exactly at PLATFORM_Y and vel = 0 stays grounded.
  - Negative vel never produces contact.
  - Contact requires horizontal overlap: x + 2*WIDTH ≥ PLATFORM_X and x ≤ PLATFORM_X + PLT_WIDTH.
- frame_tick while busy: ignored (no restart, no re-snapshot) and overrun is set to 1. overrun clears only on reset.
- Reset mid-frame: immediate return to IDLE, outputs 0. No partial upd_valid or done is produced afterwards.
- upd_y, upd_idx and upd_grounded hold their last values when upd_valid = 0.

Decomposition:
- Shared package physics_pkg holds:
  - PLATFORM_Y=380, PLATFORM_X=110, PLT_WIDTH=400
  - the coord_t typedef (logic signed [10:0])
  - the vel_t typedef (logic signed [7:0])
  - the sched_state_e enum (IDLE, CALC, RESOLVE)
  - a sat11 function
- One sub-module: a single instance of the existing main_plt_collision checker, parameterised with WIDTH and HEIGHT. It must take its platform constants from physics_pkg.

Test Plan:
- Landing: x=200, y=340, vel=+10 -> upd_y=348, upd_grounded=1, upd_valid exactly 2 cycles after the tick edge.
- Free fall and off-edge, NUM_PLAYERS=2:
  - character 0 at x=200, y=100, vel=+5 -> upd_y=105, grounded=0.
  - character 1 at x=0, y=340, vel=+10 -> upd_y=350, grounded=0 (no overlap, since 32 < 110).
  - done coincides with the idx=1 strobe, 4 cycles after the tick.
- Rest/jump:
  - y=348, vel=0 -> 348, grounded=1.
  - y=348, vel=-8 -> 340, grounded=0.
- Saturation: x=0, y=1020, vel=+20 -> upd_y=1023, grounded=0. Separately, y=-1020, vel=-20 -> upd_y=-1024.
- Overrun and snapshot:
  - A second frame_tick one cycle after the first -> overrun=1, no extra updates, busy timing unchanged.
  - Changing y_pos mid-frame does not alter upd_y.
- Reset mid-frame: assert rst during RESOLVE(0) -> all outputs 0 immediately. No upd_valid until the next tick, and the next frame behaves normally from idx 0.

Source files
------------

// File: rtl/physics_pkg.sv
// Shared platform geometry, coordinate types and scheduler state encoding
// for the character physics blocks.
package physics_pkg;

  localparam int PLATFORM_Y = 380;
  localparam int PLATFORM_X = 110;
  localparam int PLT_WIDTH  = 400;

  typedef logic signed [10:0] coord_t;
  typedef logic signed [7:0]  vel_t;

  typedef enum logic [1:0] {IDLE, CALC, RESOLVE} sched_state_e;

  // Clamp a 12-bit signed sum into the 11-bit screen coordinate range.
  function automatic coord_t sat11(input logic signed [11:0] s);
    if (s > 12'sd1023)       return coord_t'(11'h3FF);
    else if (s < -12'sd1024) return coord_t'(11'h400);
    else                     return coord_t'(s[10:0]);
  endfunction

endpackage

// File: rtl/main_plt_collision.sv
// Combinational landing test of one character against the main platform.
// Compared at 13 bits so bottom-edge sums never wrap.
module main_plt_collision
  import physics_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16
) (
  input  coord_t x,
  input  coord_t y,
  input  coord_t next_y,
  output logic   touching
);

  typedef logic signed [12:0] wide_t;

  localparam wide_t PY  = wide_t'(PLATFORM_Y);
  localparam wide_t PXL = wide_t'(PLATFORM_X);
  localparam wide_t PXR = wide_t'(PLATFORM_X + PLT_WIDTH);
  localparam wide_t W2  = wide_t'(2 * WIDTH);
  localparam wide_t H2  = wide_t'(2 * HEIGHT);

  wide_t x_w, y_w, ny_w;
  logic  falling, was_above, reaches, overlap;

  assign x_w  = {{2{x[10]}}, x};
  assign y_w  = {{2{y[10]}}, y};
  assign ny_w = {{2{next_y[10]}}, next_y};

  // Landing: moving down (or resting), bottom was at/above the surface and now reaches it.
  assign falling   = (ny_w >= y_w);
  assign was_above = ((y_w + H2) <= PY);
  assign reaches   = ((ny_w + H2) >= PY);
  assign overlap   = ((x_w + W2) >= PXL) && (x_w <= PXR);
  assign touching  = falling && was_above && reaches && overlap;

endmodule

// File: rtl/plt_collision_sched.sv
// Per-frame scheduler sharing one platform collision checker across all
// characters: snapshot on frame_tick, then CALC/RESOLVE per character.
module plt_collision_sched
  import physics_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int WIDTH       = 16,
  parameter int HEIGHT      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic [NUM_PLAYERS*11-1:0] x_pos,
  input  logic [NUM_PLAYERS*11-1:0] y_pos,
  input  logic [NUM_PLAYERS*8-1:0]  y_vel,
  output logic                     upd_valid,
  output logic [2:0]               upd_idx,
  output logic [10:0]              upd_y,
  output logic                     upd_grounded,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  localparam int       MAXP     = 8;
  localparam logic [2:0] LAST   = 3'(NUM_PLAYERS - 1);
  localparam coord_t   GROUND_Y = coord_t'(PLATFORM_Y - 2 * HEIGHT);

  coord_t x_in [MAXP];
  coord_t y_in [MAXP];
  vel_t   v_in [MAXP];

  // Unused slots read as zero so idx can address a fixed 8-entry table.
  for (genvar gi = 0; gi < MAXP; gi++) begin : g_unpack
    if (gi < NUM_PLAYERS) begin : g_used
      assign x_in[gi] = x_pos[11*gi +: 11];
      assign y_in[gi] = y_pos[11*gi +: 11];
      assign v_in[gi] = y_vel[8*gi +: 8];
    end else begin : g_unused
      assign x_in[gi] = '0;
      assign y_in[gi] = '0;
      assign v_in[gi] = '0;
    end
  end

  sched_state_e state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  coord_t       x_snap_q [MAXP];
  coord_t       y_snap_q [MAXP];
  vel_t         v_snap_q [MAXP];
  logic         snap_load;
  coord_t       chk_x_q, chk_x_d, chk_y_q, chk_y_d, chk_ny_q, chk_ny_d;
  logic         upd_valid_q, upd_valid_d, upd_grounded_q, upd_grounded_d;
  logic         done_q, done_d, overrun_q, overrun_d;
  logic [2:0]   upd_idx_q, upd_idx_d;
  coord_t       upd_y_q, upd_y_d;
  logic signed [11:0] sum_w;
  logic         touching;

  main_plt_collision #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_chk (
    .x        (chk_x_q),
    .y        (chk_y_q),
    .next_y   (chk_ny_q),
    .touching (touching)
  );

  assign sum_w = {y_snap_q[idx_q][10], y_snap_q[idx_q]} + {{4{v_snap_q[idx_q][7]}}, v_snap_q[idx_q]};

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    snap_load      = 1'b0;
    chk_x_d        = chk_x_q;
    chk_y_d        = chk_y_q;
    chk_ny_d       = chk_ny_q;
    upd_valid_d    = 1'b0;
    done_d         = 1'b0;
    upd_idx_d      = upd_idx_q;
    upd_y_d        = upd_y_q;
    upd_grounded_d = upd_grounded_q;
    overrun_d      = overrun_q | (frame_tick && (state_q != IDLE));
    case (state_q)
      IDLE: if (frame_tick) begin
        snap_load = 1'b1;
        idx_d     = '0;
        state_d   = CALC;
      end
      CALC: begin
        chk_x_d  = x_snap_q[idx_q];
        chk_y_d  = y_snap_q[idx_q];
        chk_ny_d = sat11(sum_w);
        state_d  = RESOLVE;
      end
      RESOLVE: begin
        upd_valid_d    = 1'b1;
        upd_idx_d      = idx_q;
        upd_y_d        = touching ? GROUND_Y : chk_ny_q;
        upd_grounded_d = touching;
        if (idx_q == LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = CALC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      chk_x_q        <= '0;
      chk_y_q        <= '0;
      chk_ny_q       <= '0;
      upd_valid_q    <= 1'b0;
      upd_idx_q      <= '0;
      upd_y_q        <= '0;
      upd_grounded_q <= 1'b0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
      for (int i = 0; i < MAXP; i++) begin
        x_snap_q[i] <= '0;
        y_snap_q[i] <= '0;
        v_snap_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      chk_x_q        <= chk_x_d;
      chk_y_q        <= chk_y_d;
      chk_ny_q       <= chk_ny_d;
      upd_valid_q    <= upd_valid_d;
      upd_idx_q      <= upd_idx_d;
      upd_y_q        <= upd_y_d;
      upd_grounded_q <= upd_grounded_d;
      done_q         <= done_d;
      overrun_q      <= overrun_d;
      if (snap_load) begin
        for (int i = 0; i < MAXP; i++) begin
          x_snap_q[i] <= x_in[i];
          y_snap_q[i] <= y_in[i];
          v_snap_q[i] <= v_in[i];
        end
      end
    end
  end

  assign upd_valid    = upd_valid_q;
  assign upd_idx      = upd_idx_q;
  assign upd_y        = upd_y_q;
  assign upd_grounded = upd_grounded_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_plt_collision_sched.sv
// Randomized and directed frames checked cycle by cycle against a
// behavioural landing model.
module tb_plt_collision_sched;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_tick = 1'b0;
  logic [N*11-1:0] x_pos = '0;
  logic [N*11-1:0] y_pos = '0;
  logic [N*8-1:0]  y_vel = '0;
  logic            upd_valid, upd_grounded, busy, done, overrun;
  logic [2:0]      upd_idx;
  logic [10:0]     upd_y;

  int checks = 0;
  int errors = 0;
  int fx[N], fy[N], fv[N];
  int last_y, last_g, last_idx, exp_ovr;

  plt_collision_sched #(.NUM_PLAYERS(N), .WIDTH(16), .HEIGHT(16)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .x_pos(x_pos), .y_pos(y_pos), .y_vel(y_vel),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_y(upd_y),
    .upd_grounded(upd_grounded), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: integer motion, clamp to screen range, land if the bottom
  // crosses or rests on the surface while moving down over the platform span.
  task automatic model(input int x, input int y, input int v, output int ny, output int g);
    int s;
    s  = y + v;
    ny = (s > 1023) ? 1023 : (s < -1024) ? -1024 : s;
    g  = (v >= 0) && (y + 32 <= 380) && (ny + 32 >= 380) && (x + 32 >= 110) && (x <= 510);
    if (g) ny = 348;
  endtask

  task automatic run_frame(input bit mid_change, input bit dbl);
    int ey[N], eg[N];
    for (int k = 0; k < N; k++) model(fx[k], fy[k], fv[k], ey[k], eg[k]);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      x_pos[11*k +: 11] = 11'(fx[k]);
      y_pos[11*k +: 11] = 11'(fy[k]);
      y_vel[8*k +: 8]   = 8'(fv[k]);
    end
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    check("busy_start", int'(busy), 1);
    for (int c = 1; c <= 2*N; c++) begin
      @(posedge clk); #1;
      if (mid_change && c == 1) for (int k = 0; k < N; k++) y_pos[11*k +: 11] = 11'(fy[k] - 37);
      if (dbl && c == 1) frame_tick = 1'b1;
      if (dbl && c == 2) begin frame_tick = 1'b0; exp_ovr = 1; end
      if (c % 2 == 0) begin
        last_idx = c/2 - 1;
        last_y   = ey[last_idx];
        last_g   = eg[last_idx];
      end
      check("upd_valid", int'(upd_valid), int'(c % 2 == 0));
      check("upd_idx", int'(upd_idx), last_idx);
      check("upd_y", int'($signed(upd_y)), last_y);
      check("upd_grounded", int'(upd_grounded), last_g);
      check("done", int'(done), int'(c == 2*N));
      check("busy", int'(busy), int'(c < 2*N));
      check("overrun", int'(overrun), exp_ovr);
    end
    @(posedge clk); #1;
    check("valid_after", int'(upd_valid), 0);
    check("y_hold", int'($signed(upd_y)), last_y);
  endtask

  task automatic set_chars(input int x0, y0, v0, x1, y1, v1);
    fx[0] = x0; fy[0] = y0; fv[0] = v0;
    fx[1] = x1; fy[1] = y1; fv[1] = v1;
  endtask

  initial begin
    last_y = 0; last_g = 0; last_idx = 0; exp_ovr = 0;
    #12;
    check("rst_valid", int'(upd_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_upd_y", int'(upd_y), 0);
    @(negedge clk); rst = 1'b0;

    set_chars(200, 340, 10, 200, 100, 5);    run_frame(0, 0);  // landing
    set_chars(200, 100, 5, 0, 340, 10);      run_frame(0, 0);  // free fall / off edge
    set_chars(200, 348, 0, 200, 348, -8);    run_frame(0, 0);  // rest / jump
    set_chars(0, 1020, 20, 300, -1020, -20); run_frame(0, 0);  // saturation
    set_chars(300, 330, 15, 500, 200, 3);    run_frame(1, 1);  // snapshot + overrun

    // Reset during RESOLVE(0).
    set_chars(200, 340, 10, 250, 345, 20);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      x_pos[11*k +: 11] = 11'(fx[k]);
      y_pos[11*k +: 11] = 11'(fy[k]);
      y_vel[8*k +: 8]   = 8'(fv[k]);
    end
    frame_tick = 1'b1;
    @(posedge clk); #1; frame_tick = 1'b0;
    @(posedge clk); #1; rst = 1'b1; #1;
    check("mid_rst_valid", int'(upd_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    check("mid_rst_upd_y", int'(upd_y), 0);
    check("mid_rst_idx", int'(upd_idx), 0);
    last_y = 0; last_g = 0; last_idx = 0; exp_ovr = 0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_valid", int'(upd_valid), 0);
      check("post_rst_done", int'(done), 0);
    end
    run_frame(0, 0);

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < N; k++) begin
        bit near;
        near  = 1'($urandom_range(0, 1));
        fx[k] = int'($urandom_range(0, 900)) - 200;
        fy[k] = near ? int'($urandom_range(300, 390)) : int'($urandom_range(0, 2047)) - 1024;
        fv[k] = near ? int'($urandom_range(0, 40)) - 20 : int'($urandom_range(0, 255)) - 128;
      end
      run_frame(0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
